// File: rtl/intdec_range_printer_if.sv
// rtl/intdec_range_printer_if.sv - byte stream bundle from the range printer to the UART transmitter
interface intdec_range_printer_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_byte,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_byte,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/intdec_range_printer.sv
// rtl/intdec_range_printer.sv - prints a stepped integer range as decimal ASCII lines
module intdec_range_printer #(
  parameter int         W      = 16,
  parameter int         NDIG   = 5,
  parameter logic [7:0] DELIM1 = 8'd13,
  parameter logic [7:0] DELIM2 = 8'd10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [W-1:0]           lo,
  input  logic [W-1:0]           hi,
  input  logic [W-1:0]           step,
  input  logic                   down,
  intdec_range_printer_if.master tx,
  output logic [W-1:0]           result,
  output logic [W-1:0]           count,
  output logic                   result_ready
);

  localparam int BW = NDIG * 4;
  localparam int CW = $clog2(W + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [2:0] {IDLE, CONV, EMIT, DLM1, DLM2, NEXT} state_t;

  state_t         state;
  logic [W-1:0]   i;
  logic [W-1:0]   hi_r;
  logic [W-1:0]   step_r;
  logic           down_r;
  logic [W-1:0]   bin;
  logic [BW-1:0]  bcd;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [7:0]     byte_r;
  logic           valid_r;

  logic [BW-1:0]  bcd_adj;
  logic [W:0]     up_sum;
  logic [W:0]     dn_diff;
  logic [W-1:0]   i_next;
  logic           stop_run;
  logic [3:0]     cur_dig;
  logic [3:0]     nxt_dig;

  // Pick BCD digit k (0 = least significant) out of the conversion register.
  function automatic logic [3:0] digit_at(input logic [BW-1:0] b, input logic [IW-1:0] k);
    logic [BW-1:0] s;
    s = b >> {k, 2'b00};
    return s[3:0];
  endfunction

  assign tx.out_byte  = byte_r;
  assign tx.out_valid = valid_r;
  assign result_ready = (state == IDLE) & ~start;

  // Double-dabble correction: any digit of 5 or more gets +3 before the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // The W+1-bit sum/difference exposes carry and borrow for the termination test.
  assign up_sum   = {1'b0, i} + {1'b0, step_r};
  assign dn_diff  = {1'b0, i} - {1'b0, step_r};
  assign i_next   = down_r ? dn_diff[W-1:0] : up_sum[W-1:0];
  assign stop_run = (i == hi_r) ||
                    (down_r ? (dn_diff[W] || (dn_diff[W-1:0] < hi_r))
                            : (up_sum[W]  || (up_sum[W-1:0]  > hi_r)));
  assign cur_dig  = digit_at(bcd, idx);
  assign nxt_dig  = digit_at(bcd, idx - 1'b1);

  // Main sequencer: start overrides everything, then convert, emit digits, delimiters, advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      hi_r    <= '0;
      step_r  <= '0;
      down_r  <= 1'b0;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      idx     <= '0;
      byte_r  <= '0;
      valid_r <= 1'b0;
      result  <= '0;
      count   <= '0;
    end else if (start) begin
      state   <= CONV;
      i       <= lo;
      bin     <= lo;
      bcd     <= '0;
      cnt     <= '0;
      hi_r    <= hi;
      step_r  <= (step == '0) ? {{(W-1){1'b0}}, 1'b1} : step;
      down_r  <= down;
      count   <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= EMIT;
            idx   <= IW'(NDIG - 1);
          end
        end
        EMIT: begin
          if (!valid_r) begin
            // Skip leading zeros one digit per cycle; the last digit is always sent.
            if ((cur_dig == 4'd0) && (idx != '0)) begin
              idx <= idx - 1'b1;
            end else begin
              byte_r  <= 8'h30 + {4'h0, cur_dig};
              valid_r <= 1'b1;
            end
          end else if (tx.out_ready) begin
            if (idx == '0) begin
              byte_r <= DELIM1;
              state  <= DLM1;
            end else begin
              idx    <= idx - 1'b1;
              byte_r <= 8'h30 + {4'h0, nxt_dig};
            end
          end
        end
        DLM1: begin
          if (tx.out_ready) begin
            byte_r <= DELIM2;
            state  <= DLM2;
          end
        end
        DLM2: begin
          if (tx.out_ready) begin
            valid_r <= 1'b0;
            state   <= NEXT;
          end
        end
        NEXT: begin
          result <= i;
          count  <= count + 1'b1;
          if (stop_run) begin
            state <= IDLE;
          end else begin
            i     <= i_next;
            bin   <= i_next;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intdec_range_printer.sv
// tb/tb_intdec_range_printer.sv - scoreboard bench for the decimal range printer
module tb_intdec_range_printer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [15:0] step;
  logic        down;
  logic [15:0] result;
  logic [15:0] count;
  logic        result_ready;

  intdec_range_printer_if tx ();

  intdec_range_printer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .lo           (lo),
    .hi           (hi),
    .step         (step),
    .down         (down),
    .tx           (tx.master),
    .result       (result),
    .count        (count),
    .result_ready (result_ready)
  );

  int       checks   = 0;
  int       failures = 0;
  bit [7:0] exp_q[$];
  int       exp_result;
  int       exp_count;
  bit       rnd_ready  = 0;
  bit       force_low  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: walk the range with plain integer arithmetic, queue the expected text.
  task automatic model_run(input int l, input int h, input int st, input bit dn);
    int    v;
    int    nv;
    string s;
    v = l;
    exp_count = 0;
    if (st == 0) st = 1;
    while (1) begin
      s = $sformatf("%0d", v);
      for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
      exp_q.push_back(8'd13);
      exp_q.push_back(8'd10);
      exp_count++;
      exp_result = v;
      if (v == h) break;
      nv = dn ? v - st : v + st;
      if (!dn && (nv > h || nv > 65535)) break;
      if (dn && nv < h) break;
      v = nv;
    end
  endtask

  // out_ready driver: updated 2 time units after each rising edge.
  initial begin
    tx.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (force_low) tx.out_ready = 1'b0;
      else if (rnd_ready) tx.out_ready = 1'($urandom_range(0, 1));
      else tx.out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks holding of a stalled byte.
  initial begin
    bit       pv = 0;
    bit       pr = 0;
    bit       ps = 0;
    bit [7:0] pb = 0;
    bit [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pv && !pr && !ps && tx.out_valid)
          check("byte_hold", tx.out_byte, pb);
        if (tx.out_valid && tx.out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", tx.out_byte, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", tx.out_byte, e);
          end
        end
      end
      pv = tx.out_valid;
      pr = tx.out_ready;
      ps = start;
      pb = tx.out_byte;
    end
  end

  task automatic launch(input int l, input int h, input int st, input bit dn);
    @(posedge clk);
    #1;
    lo    = l[15:0];
    hi    = h[15:0];
    step  = st[15:0];
    down  = dn;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int n;
    n = 0;
    while (!result_ready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, result_ready, 1);
    check({name, "_result"}, result, exp_result[15:0]);
    check({name, "_count"}, count, exp_count[15:0]);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run(input string name, input int l, input int h, input int st, input bit dn);
    model_run(l, h, st, dn);
    launch(l, h, st, dn);
    finish_run(name);
  endtask

  task automatic wait_drop(input int target);
    int n;
    n = 0;
    while (exp_q.size() > target && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_bytes", (exp_q.size() <= target), 1);
  endtask

  initial begin
    int l, h, st, span;
    bit dn;
    reset = 1'b1;
    start = 1'b0;
    lo = '0; hi = '0; step = '0; down = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", tx.out_valid, 0);
    check("rst_out_byte", tx.out_byte, 0);
    check("rst_result", result, 0);
    check("rst_count", count, 0);
    check("rst_result_ready", result_ready, 1);
    reset = 1'b0;

    run("up_0_3", 0, 3, 1, 0);
    rnd_ready = 1;
    run("up_0_3_stall", 0, 3, 1, 0);
    rnd_ready = 0;
    run("carry", 65530, 65535, 4, 0);
    run("down_5", 10, 0, 5, 1);
    run("down_step0", 2, 0, 0, 1);
    run("beyond", 7, 3, 1, 0);
    run("big", 65535, 65535, 1, 0);

    // Abort mid-digit: stall the stream, restart from a new lo.
    model_run(12345, 12349, 1, 0);
    launch(12345, 12349, 1, 0);
    wait_drop(exp_q.size() - 2);
    force_low = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_run(40, 42, 1, 0);
    lo = 16'd40; hi = 16'd42; step = 16'd1; down = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_valid_low", tx.out_valid, 0);
    force_low = 0;
    finish_run("abort");

    // Asynchronous reset while converting the second value.
    model_run(500, 600, 1, 0);
    launch(500, 600, 1, 0);
    wait_drop(exp_q.size() - 5);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_result_ready", result_ready, 1);
    check("arst_count", count, 0);
    check("arst_out_valid", tx.out_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      l    = $urandom_range(0, 65535);
      span = $urandom_range(0, 40);
      dn   = 1'($urandom_range(0, 1));
      st   = $urandom_range(0, 12);
      if (dn) h = (l - span < 0) ? 0 : l - span;
      else    h = (l + span > 65535) ? 65535 : l + span;
      if ($urandom_range(0, 4) == 0) h = dn ? ((l + 3 > 65535) ? 65535 : l + 3) : ((l < 3) ? 0 : l - 3);
      rnd_ready = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d", r), l, h, st, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
